// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data-memory port of the arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold req until gnt; the memory side never stalls.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    // Requester port 0 (load/store unit)
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              done0;
    logic [DATA_W-1:0] rdata0;

    // Requester port 1 (debug / DMA loader)
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              done1;
    logic [DATA_W-1:0] rdata1;

    // Single-ported data memory
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  req0, we0, addr0, wdata0,
        output gnt0, done0, rdata0,
        input  req1, we1, addr1, wdata1,
        output gnt1, done1, rdata1,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / memory-model side
    modport master (
        output req0, we0, addr0, wdata0,
        input  gnt0, done0, rdata0,
        output req1, we1, addr1, wdata1,
        input  gnt1, done1, rdata1,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported word-addressed data memory.
// Latency: gnt one cycle after the req is sampled, done/rdata two cycles after; one access per 2 cycles.
// Backpressure: requests are only sampled in IDLE; a requester holds req/we/addr/wdata until its gnt.
module dmem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q;
    logic              cmd_port_q;
    logic              cmd_we_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic              last_port_q;

    logic              gnt0_q;
    logic              gnt1_q;
    logic              done0_q;
    logic              done1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              any_req_d;
    logic              win_port_d;
    logic              win_we_d;
    logic [ADDR_W-1:0] win_addr_d;
    logic [DATA_W-1:0] win_wdata_d;

    // Winner selection: a lone requester wins, a contested cycle goes to the port that was not served last
    always_comb begin
        any_req_d   = bus.req0 | bus.req1;
        win_port_d  = 1'b0;
        if (bus.req0 && bus.req1) begin
            win_port_d = ~last_port_q;
        end else begin
            win_port_d = bus.req1;
        end
        win_we_d    = win_port_d ? bus.we1    : bus.we0;
        win_addr_d  = win_port_d ? bus.addr1  : bus.addr0;
        win_wdata_d = win_port_d ? bus.wdata1 : bus.wdata0;
    end

    // Access sequencer: latch the winner in IDLE, complete it in BUSY; all handshake outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_port_q  <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            last_port_q <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        cmd_port_q  <= win_port_d;
                        cmd_we_q    <= win_we_d;
                        cmd_addr_q  <= win_addr_d;
                        cmd_wdata_q <= win_wdata_d;
                        last_port_q <= win_port_d;
                        if (win_port_d) begin
                            gnt1_q <= 1'b1;
                        end else begin
                            gnt0_q <= 1'b1;
                        end
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // Read data is captured only for reads; writes leave the port's rdata alone
                    if (cmd_port_q) begin
                        done1_q <= 1'b1;
                        if (!cmd_we_q) begin
                            rdata1_q <= bus.mem_rdata;
                        end
                    end else begin
                        done0_q <= 1'b1;
                        if (!cmd_we_q) begin
                            rdata0_q <= bus.mem_rdata;
                        end
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory drive is decoded from state so a reset during BUSY drops a pending write at once
    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (state_q == BUSY) begin
            bus.mem_read  = ~cmd_we_q;
            bus.mem_write = cmd_we_q;
            bus.mem_addr  = cmd_addr_q;
            bus.mem_wdata = cmd_wdata_q;
        end
    end

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64x32 behavioural data memory.
// Inputs driven and outputs checked 1ns after each rising edge.
// Requesters hold req until gnt, then drop it unless another access follows.
module tb_dmem_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic clk;
    logic rst;
    logic pre_en;

    int tests;
    int fails;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: preload while pre_en, otherwise write on posedge when mem_write
    logic [DATA_W-1:0] mem [64];
    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem[0] <= 32'd17;
            mem[1] <= 32'd9;
            mem[2] <= 32'd25;
            mem[4] <= 32'h44;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every output of the arbiter packed into one vector
    function automatic logic [127:0] all_out();
        return {20'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                bus.rdata0, bus.rdata1, bus.mem_read, bus.mem_write,
                bus.mem_addr, bus.mem_wdata};
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        rst    = 1'b1;
        pre_en = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

        // Reset state
        tick();
        tick();
        check("reset_outputs", all_out(), 128'd0);
        pre_en = 1'b0;
        rst    = 1'b0;
        tick();
        check("idle_after_reset", all_out(), 128'd0);

        // Port 0 reads addr 1
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd1;
        tick();
        check("rd1_gnt0", {bus.gnt0, bus.gnt1, bus.done0}, 3'b100);
        check("rd1_mem", {bus.mem_read, bus.mem_write, bus.mem_addr}, {2'b10, 6'd1});
        bus.req0 = 1'b0;
        tick();
        check("rd1_done0", {bus.gnt0, bus.done0, bus.done1}, 3'b010);
        check("rd1_rdata0", bus.rdata0, 32'd9);
        check("rd1_rdata1", bus.rdata1, 32'd0);
        check("rd1_mem_idle", {bus.mem_read, bus.mem_write}, 2'b00);

        // Port 1 writes 0xDEADBEEF to addr 5
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'd5; bus.wdata1 = 32'hDEADBEEF;
        tick();
        check("wr5_gnt1", {bus.gnt0, bus.gnt1}, 2'b01);
        check("wr5_mem", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata},
              {2'b01, 6'd5, 32'hDEADBEEF});
        bus.req1 = 1'b0;
        tick();
        check("wr5_done1", {bus.done0, bus.done1}, 2'b01);
        check("wr5_rdata1_kept", bus.rdata1, 32'd0);

        // Port 0 reads addr 5 back
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd5;
        tick();
        check("rd5_gnt0", {bus.gnt0, bus.gnt1}, 2'b10);
        bus.req0 = 1'b0;
        tick();
        check("rd5_done0", {bus.done0, bus.done1}, 2'b10);
        check("rd5_rdata0", bus.rdata0, 32'hDEADBEEF);
        check("rd5_rdata1_kept", bus.rdata1, 32'd0);

        // Both ports requesting continuously from reset release
        rst = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'd2;
        #1;
        check("rr_outputs_in_reset", all_out(), 128'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("rr_pulses_%0d", k),
                  {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_read},
                  {(k % 4 == 0), (k % 4 == 2), (k % 4 == 1), (k % 4 == 3), (k % 2 == 0)});
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check("rr_rdata0", bus.rdata0, 32'd17);
        check("rr_rdata1", bus.rdata1, 32'd25);

        // Port 0 write of 42 to addr 3 followed immediately by a read of addr 3
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'd3; bus.wdata0 = 32'd42;
        tick();
        check("wr3_gnt0", {bus.gnt0, bus.mem_write}, 2'b11);
        bus.we0 = 1'b0;
        tick();
        check("wr3_done0", {bus.gnt0, bus.done0}, 2'b01);
        check("wr3_rdata0_kept", bus.rdata0, 32'd17);
        tick();
        check("rd3_gnt0_two_later", {bus.gnt0, bus.done0, bus.mem_read}, 3'b101);
        bus.req0 = 1'b0;
        tick();
        check("rd3_done0", {bus.gnt0, bus.done0}, 2'b01);
        check("rd3_rdata0", bus.rdata0, 32'd42);

        // Reset during a BUSY write of 7 to addr 4
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'd4; bus.wdata0 = 32'd7;
        tick();
        check("wr4_busy", {bus.gnt0, bus.mem_write, bus.mem_addr}, {2'b11, 6'd4});
        bus.req0 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("wr4_rst_outputs", all_out(), 128'd0);
        tick();
        check("wr4_rst_edge", all_out(), 128'd0);
        rst = 1'b0;
        tick();
        check("wr4_no_done", {bus.gnt0, bus.done0, bus.mem_write}, 3'b000);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd4;
        tick();
        check("rd4_gnt0", bus.gnt0, 1'b1);
        bus.req0 = 1'b0;
        tick();
        check("rd4_done0", bus.done0, 1'b1);
        check("rd4_rdata0_preload", bus.rdata0, 32'h44);

        // Ten idle cycles
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("idle_%0d", k),
                  {bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                   bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata},
                  '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
